// File: rtl/uart_tx_queue_pkg.sv
// Shared types and defaults for the UART transmit byte queue.
// Optional overflow flag is enabled with UART_TXQ_OVF_EN (see uart_tx_queue.sv).
package uart_tx_queue_pkg;

    typedef enum logic [1:0] {
        Q_IDLE,
        Q_LAUNCH,
        Q_WAIT_BUSY,
        Q_WAIT_DONE
    } txq_state_t;

    localparam int TXQ_DEPTH_DEF  = 16;
    localparam int TXQ_DATA_W_DEF = 8;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with exact occupancy count and flush.
// Head entry is always visible on rd_data; rd_en advances the read pointer.
module uart_sync_fifo
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH  = TXQ_DEPTH_DEF,
    parameter int DATA_W = TXQ_DATA_W_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              flush,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // A full queue still accepts a write when the head leaves this cycle.
    assign w_pop  = rd_en && !empty;
    assign w_push = wr_en && !flush && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding the UART transmitter; launches one byte per idle UART.
// Define UART_TXQ_OVF_EN to add the sticky ovf flag and its ovf_clr input.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH  = TXQ_DEPTH_DEF,
    parameter int DATA_W = TXQ_DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   flush,
    input  logic                   tx_idle,
`ifdef UART_TXQ_OVF_EN
    input  logic                   ovf_clr,
    output logic                   ovf,
`endif
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [DATA_W-1:0]      Tx_Data,
    output logic                   tx_send,
    output logic                   tx_send_en,
    output logic                   busy
);

    txq_state_t        r_state;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_send;
    logic              r_busy;
    logic [DATA_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;

    assign w_pop = (r_state == Q_IDLE) && !w_empty && tx_idle;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (w_pop),
        .flush   (flush),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (count)
    );

    assign full       = w_full;
    assign empty      = w_empty;
    assign Tx_Data    = r_tx_data;
    assign tx_send    = r_send;
    assign tx_send_en = r_send;
    assign busy       = r_busy;

    // Tx_Data is loaded only on pop, so it stays frozen for the whole frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= Q_IDLE;
            r_tx_data <= '0;
            r_send    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_send <= 1'b0;
            unique case (r_state)
                Q_IDLE: begin
                    if (w_pop) begin
                        r_tx_data <= w_head;
                        r_send    <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= Q_LAUNCH;
                    end
                end
                Q_LAUNCH: begin
                    r_state <= Q_WAIT_BUSY;
                end
                Q_WAIT_BUSY: begin
                    if (!tx_idle) begin
                        r_state <= Q_WAIT_DONE;
                    end
                end
                Q_WAIT_DONE: begin
                    if (tx_idle) begin
                        r_busy  <= 1'b0;
                        r_state <= Q_IDLE;
                    end
                end
                default: begin
                    r_state <= Q_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TXQ_OVF_EN
    logic r_ovf;
    logic w_drop;

    assign w_drop = wr_en && w_full && !w_pop;
    assign ovf    = r_ovf;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a queue-level reference model
// and a simple UART stand-in that holds tx_idle low for a fixed frame time.
module tb_uart_tx_queue;
    import uart_tx_queue_pkg::*;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int ULEN  = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          flush;
    logic          tx_idle;
    logic          full;
    logic          empty;
    logic [4:0]    count;
    logic [DW-1:0] Tx_Data;
    logic          tx_send;
    logic          tx_send_en;
    logic          busy;
`ifdef UART_TXQ_OVF_EN
    logic          ovf;
    logic          ovf_clr;
`endif

    always #5 clk = ~clk;

    uart_tx_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .flush      (flush),
        .tx_idle    (tx_idle),
`ifdef UART_TXQ_OVF_EN
        .ovf_clr    (ovf_clr),
        .ovf        (ovf),
`endif
        .full       (full),
        .empty      (empty),
        .count      (count),
        .Tx_Data    (Tx_Data),
        .tx_send    (tx_send),
        .tx_send_en (tx_send_en),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: queued bytes, byte in flight, UART seen busy.
    logic [DW-1:0] q[$];
    logic [DW-1:0] rx[$];
    logic [DW-1:0] m_data = '0;
    bit            m_busy = 0;
    bit            m_low  = 0;
    bit            m_send = 0;
    bit            m_ovf  = 0;

    int ucnt         = 0;
    bit sent_pending = 0;
    int sent_cnt     = 0;
    bit stall        = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit pop_now();
        return rst && !m_busy && q.size() != 0 && tx_idle;
    endfunction

    task automatic model_cycle();
        bit full0;
        bit pop;
        bit drop;
        bit launch;
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("tx_send", 32'(tx_send), 32'(m_send));
        chk("tx_send_en", 32'(tx_send_en), 32'(m_send));
        chk("Tx_Data", 32'(Tx_Data), 32'(m_data));
        chk("busy", 32'(busy), 32'(m_busy));
`ifdef UART_TXQ_OVF_EN
        chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
        if (tx_send === 1'b1) begin
            rx.push_back(Tx_Data);
            sent_pending = 1;
            sent_cnt++;
        end
        if (!rst) begin
            q.delete();
            m_data = '0;
            m_busy = 0;
            m_low  = 0;
            m_send = 0;
            m_ovf  = 0;
        end else begin
            launch = m_send;
            full0  = (q.size() == DEPTH);
            pop    = pop_now();
            drop   = wr_en && full0 && !pop;
            if (pop) begin
                m_data = q.pop_front();
                m_busy = 1;
                m_low  = 0;
            end else if (m_busy && !launch) begin
                if (!m_low) begin
                    if (!tx_idle) m_low = 1;
                end else if (tx_idle) begin
                    m_busy = 0;
                end
            end
            if (flush) q.delete();
            else if (wr_en && (!full0 || pop)) q.push_back(wr_data);
`ifdef UART_TXQ_OVF_EN
            if (drop) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
`else
            if (drop) m_ovf = 1;
`endif
            m_send = pop;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        if (!rst) begin
            ucnt = 0;
            sent_pending = 0;
        end else if (sent_pending) begin
            sent_pending = 0;
            ucnt = ULEN;
        end else if (ucnt > 0) begin
            ucnt--;
        end
        tx_idle = !stall && ucnt == 0;
        wr_en = 1'b0;
        flush = 1'b0;
`ifdef UART_TXQ_OVF_EN
        ovf_clr = 1'b0;
`endif
    endtask

    task automatic drain(string name, int budget);
        int k = 0;
        while ((q.size() != 0 || m_busy || !tx_idle) && k < budget) begin
            step();
            k++;
        end
        n_checks++;
        if (k >= budget) begin
            n_fail++;
            $display("FAIL %s: drain got %0d cycles expected < %0d", name, k, budget);
        end
    endtask

    task automatic wait_in_flight(string name, int budget);
        int k = 0;
        while (!(m_busy && m_low) && k < budget) begin
            step();
            k++;
        end
        n_checks++;
        if (k >= budget) begin
            n_fail++;
            $display("FAIL %s: in-flight wait got %0d cycles expected < %0d", name, k, budget);
        end
    endtask

    initial begin
        logic [DW-1:0] t2 [3];
        int s0;
        int k;
        t2[0] = 8'hEA;
        t2[1] = 8'h50;
        t2[2] = 8'hA5;
        rst = 1'b0;
        wr_en = 1'b0;
        wr_data = '0;
        flush = 1'b0;
        tx_idle = 1'b1;
`ifdef UART_TXQ_OVF_EN
        ovf_clr = 1'b0;
`endif
        step();
        step();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_send", 32'(tx_send), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data", 32'(Tx_Data), 0);
        rst = 1'b1;
        step();

        // 1: single byte, two-cycle launch latency
        rx.delete();
        wr_en = 1'b1;
        wr_data = 8'hEA;
        step();
        chk("t1_count", 32'(count), 1);
        chk("t1_early", 32'(tx_send), 0);
        step();
        chk("t1_send", 32'(tx_send), 1);
        chk("t1_send_en", 32'(tx_send_en), 1);
        chk("t1_data", 32'(Tx_Data), 32'h EA);
        chk("t1_busy", 32'(busy), 1);
        drain("t1", 100);
        chk("t1_rx_n", 32'(rx.size()), 1);
        if (rx.size() > 0) chk("t1_rx0", 32'(rx[0]), 32'hEA);

        // 2: three back-to-back writes while the UART is busy elsewhere
        rx.delete();
        s0 = sent_cnt;
        stall = 1;
        tx_idle = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            wr_data = t2[i];
            step();
            chk("t2_count", 32'(count), 32'(i + 1));
        end
        stall = 0;
        tx_idle = (ucnt == 0);
        drain("t2", 200);
        chk("t2_sends", 32'(sent_cnt - s0), 3);
        chk("t2_rx_n", 32'(rx.size()), 3);
        for (int i = 0; i < rx.size() && i < 3; i++) chk("t2_rx", 32'(rx[i]), 32'(t2[i]));

        // 3: fill to full with the UART stalled, then overflow
        rx.delete();
        stall = 1;
        tx_idle = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h10 + i);
            step();
        end
        chk("t3_full", 32'(full), 1);
        chk("t3_count", 32'(count), 16);
        wr_en = 1'b1;
        wr_data = 8'hFF;
        step();
        chk("t3_drop_count", 32'(count), 16);
`ifdef UART_TXQ_OVF_EN
        chk("t3_ovf", 32'(ovf), 1);
        step();
        chk("t3_ovf_hold", 32'(ovf), 1);
        ovf_clr = 1'b1;
        step();
        chk("t3_ovf_clr", 32'(ovf), 0);
`endif

        // 4: write while popping a full queue, wrap through 20 bytes
        stall = 0;
        tx_idle = (ucnt == 0);
        for (int j = 0; j < 4; j++) begin
            k = 0;
            while (!pop_now() && k < 100) begin
                step();
                k++;
            end
            wr_en = 1'b1;
            wr_data = 8'(8'h20 + j);
            step();
            chk("t4_count", 32'(count), 16);
            chk("t4_full", 32'(full), 1);
        end
        drain("t4", 400);
        chk("t4_rx_n", 32'(rx.size()), 20);
        for (int i = 0; i < rx.size() && i < 20; i++) begin
            chk("t4_rx", 32'(rx[i]), (i < 16) ? 32'(8'h10 + i) : 32'(8'h20 + i - 16));
        end

        // 5: flush while the first of four bytes is on the line
        rx.delete();
        s0 = sent_cnt;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h31 + i);
            step();
        end
        wait_in_flight("t5", 50);
        flush = 1'b1;
        step();
        chk("t5_empty", 32'(empty), 1);
        chk("t5_count", 32'(count), 0);
        drain("t5", 100);
        for (int i = 0; i < 20; i++) step();
        chk("t5_sends", 32'(sent_cnt - s0), 1);
        chk("t5_rx_n", 32'(rx.size()), 1);
        if (rx.size() > 0) chk("t5_rx0", 32'(rx[0]), 32'h31);

        // 6: reset while waiting for the frame to finish
        wr_en = 1'b1;
        wr_data = 8'h5A;
        step();
        wr_en = 1'b1;
        wr_data = 8'h6B;
        step();
        wait_in_flight("t6", 50);
        rst = 1'b0;
        step();
        chk("t6_busy", 32'(busy), 0);
        chk("t6_send", 32'(tx_send), 0);
        chk("t6_data", 32'(Tx_Data), 0);
        chk("t6_count", 32'(count), 0);
        chk("t6_empty", 32'(empty), 1);
        rst = 1'b1;
        step();
        wr_en = 1'b1;
        wr_data = 8'h77;
        step();
        step();
        chk("t6_relaunch", 32'(tx_send), 1);
        chk("t6_redata", 32'(Tx_Data), 32'h77);
        drain("t6", 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
